clock_step_controller: RTL and testbench
========================================

Name: clock_step_controller

Overview:
- Sequences the CPU core clock-enable from the front-panel controls.
- Supported modes: free run, single-cycle step, single-instruction step, run-to-breakpoint, and a push-button CPU reset.
- Sits between the panel inputs (step button, mode switches, breakpoint address) and the core: it gates every microcycle via o_cpuClkEn and consumes the core's PC and instruction-boundary flag.

Parameters:
- DEBOUNCE_CYCLES, 8: oszClk cycles an input must hold a new level before the debounced level changes.
- RESET_CYCLES, 4: oszClk cycles o_cpuReset is held after a reset-button press.
- ADDR_W, 16: PC and breakpoint address width.

Ports:
- oszClk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-high reset.
- i_btnStep  in  1  raw step button, 1 = closed.
- i_btnReset  in  1  raw reset button, 1 = closed.
- i_swStepNRun  in  1  1 = step mode, 0 = run.
- i_swInstrNCycle  in  1  1 = step whole instruction, 0 = step one cycle.
- i_swEnableBreakpoint  in  1  1 = breakpoint armed.
- i_breakpointAddress  in  ADDR_W  breakpoint PC.
- i_pc  in  ADDR_W  core PC, valid when i_instrStart = 1.
- i_instrStart  in  1  next enabled core cycle is the first microcycle of a new instruction.
- o_cpuClkEn  out  1  core advances one microcycle on each oszClk edge where this is 1.
- o_cpuReset  out  1  synchronous reset to core.
- o_running  out  1  state is RUN.
- o_breakHit  out  1  one-cycle pulse when a breakpoint halts execution.

Behaviour:
- Reset (resetn = 1):
  - state = RESET_HOLD, counter loaded with RESET_CYCLES-1.
  - o_cpuReset = 1, o_cpuClkEn = 0, o_running = 0, o_breakHit = 0.
  - Debounced levels = 0; skipBp = 0.
- Debounce:
  - Applies to both buttons: 2-flop synchroniser, then a counter.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples that differ from the current level.
  - Rising-edge detect on the debounced level gives a one-cycle press pulse.
  - Total latency from raw change to press pulse = DEBOUNCE_CYCLES + 2 cycles.
  - Switches are synchronised only, not debounced.
- States: RESET_HOLD, HALTED, RUN, STEP_CYCLE, STEP_INSTR.
- RESET_HOLD:
  - o_cpuReset = 1; counter decrements each cycle.
  - At 0: go to HALTED if swStepNRun = 1, else RUN.
- HALTED:
  - o_cpuClkEn = 0.
  - If swStepNRun = 0: go to RUN.
  - Else on step press: go to STEP_INSTR if swInstrNCycle = 1, else STEP_CYCLE.
- STEP_CYCLE: o_cpuClkEn = 1 for exactly one cycle, then HALTED.
- STEP_INSTR:
  - o_cpuClkEn = 1 every cycle.
  - Exits to HALTED on the first cycle after at least one enabled cycle in which i_instrStart = 1; o_cpuClkEn = 0 in that exit cycle.
- RUN:
  - o_cpuClkEn = 1 unless bpMatch.
  - bpMatch = i_swEnableBreakpoint & i_instrStart & (i_pc == i_breakpointAddress) & ~skipBp.
  - On bpMatch: o_cpuClkEn = 0 that cycle, o_breakHit pulses, next state = HALTED.
  - swStepNRun = 1 while running: finish the current cycle, then go to HALTED.
- skipBp:
  - Set on every exit from HALTED.
  - Cleared after the first enabled cycle with i_instrStart = 1.
  - Purpose: resuming from a breakpoint does not re-halt on the same instruction.
- o_cpuClkEn is combinational from state and bpMatch. All other outputs are registered.
- Reset press in any state:
  - Go to RESET_HOLD and reload the counter.
  - o_cpuClkEn = 0 from the next cycle.
  - A pending step press is discarded.
- Simultaneous events:
  - A reset press beats a step press.
  - A step press in a non-HALTED state is ignored (not queued).
- Breakpoint at address 0 after reset halts before the first instruction, because skipBp = 0 out of RESET_HOLD.
- Step-mode switch changes take effect only in HALTED or RUN.

Decomposition:
- Package clock_ctrl_pkg holds:
  - typedef enum ctrl_state_t {RESET_HOLD, HALTED, RUN, STEP_CYCLE, STEP_INSTR};
  - default DEBOUNCE_CYCLES and RESET_CYCLES constants.
- One sub-module, button_debouncer: synchroniser, counter and press pulse. Instantiated twice, for step and reset.

Test Plan:
- Power-up: resetn = 1 for 3 cycles, then 0, with swStepNRun = 0. o_cpuReset stays 1 for exactly 4 cycles after resetn falls, then o_running = 1 and o_cpuClkEn = 1 continuously.
- Cycle step: swStepNRun = 1, swInstrNCycle = 0, DEBOUNCE_CYCLES = 4; hold btnStep for 10 cycles. Exactly one o_cpuClkEn pulse, 6 cycles after the press. A 3-cycle glitch produces no pulse.
- Instruction step: core model asserts i_instrStart every 4th enabled cycle; one press produces exactly 4 o_cpuClkEn cycles, then HALTED.
- Breakpoint: run with bp = 0x0028 and the PC model reaching 0x0028. o_breakHit pulses once, o_cpuClkEn = 0 from that cycle, state = HALTED. Flip swStepNRun to 0: execution resumes past 0x0028 without re-halting, and halts again on the next visit.
- Reset mid-step: press btnReset during STEP_INSTR. o_cpuClkEn drops to 0, o_cpuReset = 1 for 4 cycles, and the press is not replayed.
- Breakpoint disabled: same as the breakpoint scenario with swEnableBreakpoint = 0. o_breakHit never pulses and o_cpuClkEn stays 1.

Source files
------------

// File: rtl/clock_step_controller_pkg.sv
// Purpose: shared state encoding and default timing constants for the clock-step controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    HALTED,
    RUN,
    STEP_CYCLE,
    STEP_INSTR
  } ctrl_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
  localparam int DEFAULT_RESET_CYCLES    = 4;
  localparam int DEFAULT_ADDR_W          = 16;

  // Width of a down/up counter covering 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// Purpose: bundles the front-panel inputs and the core-side clock-enable signals.
// Latency: n/a (wires only).
// Backpressure: n/a; the core is throttled solely through o_cpuClkEn.
interface clock_step_controller_if
  import clock_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic              i_btnStep;
  logic              i_btnReset;
  logic              i_swStepNRun;
  logic              i_swInstrNCycle;
  logic              i_swEnableBreakpoint;
  logic [ADDR_W-1:0] i_breakpointAddress;
  logic [ADDR_W-1:0] i_pc;
  logic              i_instrStart;
  logic              o_cpuClkEn;
  logic              o_cpuReset;
  logic              o_running;
  logic              o_breakHit;

  // Panel and core side: drives the controls, consumes the enable.
  modport master (
    output i_btnStep, i_btnReset, i_swStepNRun, i_swInstrNCycle, i_swEnableBreakpoint,
    output i_breakpointAddress, i_pc, i_instrStart,
    input  o_cpuClkEn, o_cpuReset, o_running, o_breakHit
  );

  // Controller side.
  modport slave (
    input  i_btnStep, i_btnReset, i_swStepNRun, i_swInstrNCycle, i_swEnableBreakpoint,
    input  i_breakpointAddress, i_pc, i_instrStart,
    output o_cpuClkEn, o_cpuReset, o_running, o_breakHit
  );

endinterface

// File: rtl/clock_step_controller_button_debouncer.sv
// Purpose: synchronise and debounce one raw button, emit a one-cycle press pulse on a debounced rising edge.
// Latency: press pulse DEBOUNCE_CYCLES+2 cycles after the raw button closes.
// Backpressure: none; a press is a single-cycle pulse and is not held for the consumer.
module button_debouncer
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic oszClk,
  input  logic resetn,
  input  logic btnRaw,
  output logic btnPress
);

  localparam int            CW       = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncA;
  logic          syncB;
  logic          btnLevel;
  logic [CW-1:0] holdCnt;

  // Two-flop synchroniser for the asynchronous button contact.
  always_ff @(posedge oszClk or posedge resetn) begin
    if (resetn) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
    end
  end

  // Accept a new level only after it has been stable for the full hold window; flag rising edges.
  always_ff @(posedge oszClk or posedge resetn) begin
    if (resetn) begin
      holdCnt  <= '0;
      btnLevel <= 1'b0;
      btnPress <= 1'b0;
    end else begin
      btnPress <= 1'b0;
      if (syncB == btnLevel) begin
        holdCnt <= '0;
      end else if (holdCnt == CNT_LAST) begin
        holdCnt  <= '0;
        btnLevel <= syncB;
        btnPress <= syncB;
      end else begin
        holdCnt <= holdCnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_step_controller.sv
// Purpose: sequences the CPU core clock-enable from panel controls (run, cycle/instruction step, breakpoint, reset).
// Latency: o_cpuClkEn combinational from state and breakpoint compare; button action DEBOUNCE_CYCLES+3 cycles after press.
// Backpressure: none; the core advances only on cycles where o_cpuClkEn is high, step presses outside HALTED are dropped.
module clock_step_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RESET_CYCLES    = DEFAULT_RESET_CYCLES
) (
  input logic                    oszClk,
  input logic                    resetn,
  clock_step_controller_if.slave bus
);

  localparam int             RCW        = cntWidth(RESET_CYCLES);
  localparam logic [RCW-1:0] RESET_LOAD = RCW'(RESET_CYCLES - 1);

  ctrl_state_t    state;
  logic [RCW-1:0] resetCnt;
  logic           cpuReset;
  logic           running;
  logic           breakHit;
  logic           skipBp;
  logic           instrDone;
  logic           cpuClkEn;
  logic           bpMatch;
  logic           stepPress;
  logic           resetPress;
  logic [2:0]     swMeta;
  logic [2:0]     swSync;
  logic           stepMode;
  logic           instrMode;
  logic           bpEnable;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStepBtn (
    .oszClk   (oszClk),
    .resetn   (resetn),
    .btnRaw   (bus.i_btnStep),
    .btnPress (stepPress)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uResetBtn (
    .oszClk   (oszClk),
    .resetn   (resetn),
    .btnRaw   (bus.i_btnReset),
    .btnPress (resetPress)
  );

  // Switches only need metastability protection; they are not debounced.
  always_ff @(posedge oszClk or posedge resetn) begin
    if (resetn) begin
      swMeta <= 3'b000;
      swSync <= 3'b000;
    end else begin
      swMeta <= {bus.i_swStepNRun, bus.i_swInstrNCycle, bus.i_swEnableBreakpoint};
      swSync <= swMeta;
    end
  end

  assign stepMode  = swSync[2];
  assign instrMode = swSync[1];
  assign bpEnable  = swSync[0];

  // skipBp masks the breakpoint on the instruction we just resumed from.
  assign bpMatch = bpEnable & bus.i_instrStart & (bus.i_pc == bus.i_breakpointAddress) & ~skipBp;

  // Clock enable is decided in the same cycle so a breakpoint never lets its instruction start.
  always_comb begin
    cpuClkEn = 1'b0;
    case (state)
      RUN:        cpuClkEn = ~bpMatch;
      STEP_CYCLE: cpuClkEn = 1'b1;
      STEP_INSTR: cpuClkEn = ~(instrDone & bus.i_instrStart);
      default:    cpuClkEn = 1'b0;
    endcase
  end

  // Main sequencer; reset press overrides everything, outputs are registered alongside the state.
  always_ff @(posedge oszClk or posedge resetn) begin
    if (resetn) begin
      state     <= RESET_HOLD;
      resetCnt  <= RESET_LOAD;
      cpuReset  <= 1'b1;
      running   <= 1'b0;
      breakHit  <= 1'b0;
      skipBp    <= 1'b0;
      instrDone <= 1'b0;
    end else if (resetPress) begin
      state     <= RESET_HOLD;
      resetCnt  <= RESET_LOAD;
      cpuReset  <= 1'b1;
      running   <= 1'b0;
      breakHit  <= 1'b0;
      skipBp    <= 1'b0;
      instrDone <= 1'b0;
    end else begin
      breakHit <= 1'b0;
      if (cpuClkEn && bus.i_instrStart) begin
        skipBp <= 1'b0;
      end
      case (state)
        RESET_HOLD: begin
          if (resetCnt == '0) begin
            cpuReset <= 1'b0;
            if (stepMode) begin
              state <= HALTED;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end else begin
            resetCnt <= resetCnt - RCW'(1);
          end
        end
        HALTED: begin
          if (!stepMode) begin
            state   <= RUN;
            running <= 1'b1;
            skipBp  <= 1'b1;
          end else if (stepPress) begin
            state     <= instrMode ? STEP_INSTR : STEP_CYCLE;
            skipBp    <= 1'b1;
            instrDone <= 1'b0;
          end
        end
        RUN: begin
          if (bpMatch) begin
            state    <= HALTED;
            running  <= 1'b0;
            breakHit <= 1'b1;
          end else if (stepMode) begin
            state   <= HALTED;
            running <= 1'b0;
          end
        end
        STEP_CYCLE: begin
          state <= HALTED;
        end
        STEP_INSTR: begin
          if (instrDone && bus.i_instrStart) begin
            state <= HALTED;
          end else begin
            instrDone <= 1'b1;
          end
        end
        default: begin
          state    <= RESET_HOLD;
          resetCnt <= RESET_LOAD;
          cpuReset <= 1'b1;
          running  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cpuClkEn = cpuClkEn;
  assign bus.o_cpuReset = cpuReset;
  assign bus.o_running  = running;
  assign bus.o_breakHit = breakHit;

endmodule

// File: tb/tb_clock_step_controller.sv
// Purpose: self-checking bench for clock_step_controller with a small 4-microcycle core model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_step_controller;

  logic oszClk = 1'b0;
  logic resetn = 1'b0;

  clock_step_controller_if #(.ADDR_W(16)) bus ();

  clock_step_controller #(
    .DEBOUNCE_CYCLES (4),
    .RESET_CYCLES    (4)
  ) dut (
    .oszClk (oszClk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 oszClk = ~oszClk;

  // Core model: every instruction is 4 microcycles, PC steps by 4 and wraps after 0x003C.
  logic [1:0]  coreUc = 2'd0;
  logic [15:0] corePc = 16'h0000;
  logic        ovr = 1'b0;
  logic [15:0] ovrPc = 16'h0000;
  logic        ovrStart = 1'b0;

  always @(posedge oszClk) begin
    if (bus.o_cpuReset) begin
      coreUc <= 2'd0;
      corePc <= 16'h0000;
    end else if (bus.o_cpuClkEn) begin
      coreUc <= coreUc + 2'd1;
      if (coreUc == 2'd3) corePc <= (corePc == 16'h003C) ? 16'h0000 : corePc + 16'h0004;
    end
  end

  assign bus.i_pc         = ovr ? ovrPc : corePc;
  assign bus.i_instrStart = ovr ? ovrStart : (coreUc == 2'd0);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Runs len cycles from the current negedge; c==0 is now, sample c is taken after posedge c.
  task automatic pressWindow(input int stepAt, input int resetAt, input int releaseAt, input int len,
                             output int enCnt, output int enFirst, output int enLast,
                             output int rstCnt, output int rstFirst);
    enCnt = 0; enFirst = -1; enLast = -1; rstCnt = 0; rstFirst = -1;
    for (int c = 0; c <= len; c++) begin
      if (c > 0) begin
        @(negedge oszClk);
        if (bus.o_cpuClkEn) begin
          enCnt++;
          if (enFirst < 0) enFirst = c;
          enLast = c;
        end
        if (bus.o_cpuReset) begin
          rstCnt++;
          if (rstFirst < 0) rstFirst = c;
        end
      end
      if (c == stepAt) bus.i_btnStep = 1'b1;
      if (c == resetAt) bus.i_btnReset = 1'b1;
      if (c == releaseAt) begin
        bus.i_btnStep  = 1'b0;
        bus.i_btnReset = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic rstIn;
    logic expReset;
    logic expRun;
    logic expEn;
  } pu_vec_t;

  typedef struct {
    logic [15:0] pc;
    logic        start;
    logic [15:0] bp;
    logic        expEn;
  } bp_vec_t;

  pu_vec_t puTab[11];
  bp_vec_t bpTab[7];

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int found, en, bh, enCnt, enFirst, enLast, rstCnt, rstFirst;

    // Power-up: three cycles in reset, release, four cycles of core reset, then free run.
    puTab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    puTab[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    puTab[2]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    puTab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    puTab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    puTab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    puTab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    puTab[7]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    puTab[8]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    puTab[9]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    puTab[10] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Breakpoint compare while running with skipBp clear: {pc, instrStart, bp, expected enable}.
    bpTab[0] = '{16'h0028, 1'b1, 16'h0028, 1'b0};
    bpTab[1] = '{16'h0028, 1'b0, 16'h0028, 1'b1};
    bpTab[2] = '{16'h002C, 1'b1, 16'h0028, 1'b1};
    bpTab[3] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
    bpTab[4] = '{16'hFFFF, 1'b1, 16'h7FFF, 1'b1};
    bpTab[5] = '{16'hA5A5, 1'b1, 16'hA5A5, 1'b0};
    bpTab[6] = '{16'hA5A5, 1'b1, 16'hA5A4, 1'b1};

    bus.i_btnStep            = 1'b0;
    bus.i_btnReset           = 1'b0;
    bus.i_swStepNRun         = 1'b0;
    bus.i_swInstrNCycle      = 1'b0;
    bus.i_swEnableBreakpoint = 1'b1;
    bus.i_breakpointAddress  = 16'h0028;
    #1 resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge oszClk);
      resetn = puTab[i].rstIn;
      #1;
      check($sformatf("pwr_cpuReset[%0d]", i), int'(bus.o_cpuReset), int'(puTab[i].expReset));
      check($sformatf("pwr_running[%0d]", i), int'(bus.o_running), int'(puTab[i].expRun));
      check($sformatf("pwr_clkEn[%0d]", i), int'(bus.o_cpuClkEn), int'(puTab[i].expEn));
      check($sformatf("pwr_breakHit[%0d]", i), int'(bus.o_breakHit), 0);
    end

    // Combinational breakpoint vectors, all applied between two clock edges.
    @(posedge oszClk);
    #1 ovr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ovrPc = bpTab[i].pc;
      ovrStart = bpTab[i].start;
      bus.i_breakpointAddress = bpTab[i].bp;
      #1;
      check($sformatf("bp_vec[%0d]", i), int'(bus.o_cpuClkEn), int'(bpTab[i].expEn));
    end
    ovr = 1'b0;
    bus.i_breakpointAddress = 16'h0028;

    // Run to the breakpoint at 0x0028.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge oszClk);
      if (!bus.o_cpuClkEn) found = 1;
    end
    check("bp1_reached", found, 1);
    check("bp1_pc", int'(bus.i_pc), 32'h0028);
    check("bp1_running", int'(bus.o_running), 1);
    @(negedge oszClk);
    check("bp1_breakHit", int'(bus.o_breakHit), 1);
    check("bp1_halted", int'(bus.o_running), 0);
    check("bp1_clkEn_halted", int'(bus.o_cpuClkEn), 0);
    @(negedge oszClk);
    check("bp1_breakHit_clear", int'(bus.o_breakHit), 0);
    check("bp1_resume_running", int'(bus.o_running), 1);
    check("bp1_resume_clkEn", int'(bus.o_cpuClkEn), 1);
    check("bp1_resume_pc", int'(bus.i_pc), 32'h0028);

    // Next visit to 0x0028 is one full PC loop (16 instructions x 4 cycles) away.
    en = 0; found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (bus.o_cpuClkEn) en++;
      else found = 1;
      if (found == 0) @(negedge oszClk);
    end
    check("bp2_reached", found, 1);
    check("bp2_enabled_cycles", en, 64);
    check("bp2_pc", int'(bus.i_pc), 32'h0028);
    @(negedge oszClk);
    check("bp2_breakHit", int'(bus.o_breakHit), 1);

    // Breakpoint disabled: a full loop past 0x0028 with no halt.
    bus.i_swEnableBreakpoint = 1'b0;
    repeat (3) @(negedge oszClk);
    en = 0; bh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge oszClk);
      if (bus.o_cpuClkEn) en++;
      if (bus.o_breakHit) bh++;
    end
    check("nobp_clkEn_cycles", en, 100);
    check("nobp_breakHit_count", bh, 0);

    // Switch to step mode; RUN drops into HALTED.
    bus.i_swStepNRun = 1'b1;
    repeat (5) @(negedge oszClk);
    check("halt_running", int'(bus.o_running), 0);
    check("halt_clkEn", int'(bus.o_cpuClkEn), 0);

    // A 3-cycle bounce is shorter than the 4-sample hold and must not step.
    pressWindow(0, -1, 3, 15, enCnt, enFirst, enLast, rstCnt, rstFirst);
    check("glitch_clkEn_count", enCnt, 0);

    // Cycle step: one enable, 6 edges after the first edge that samples the button.
    pressWindow(0, -1, 10, 30, enCnt, enFirst, enLast, rstCnt, rstFirst);
    check("cstep_clkEn_count", enCnt, 1);
    check("cstep_latency", enFirst - 1, 6);
    check("cstep_halted", int'(bus.o_running), 0);

    // Step and reset pressed together: reset wins, no step afterwards; core model realigned.
    bus.i_swInstrNCycle = 1'b1;
    pressWindow(0, 0, 10, 30, enCnt, enFirst, enLast, rstCnt, rstFirst);
    check("both_clkEn_count", enCnt, 0);
    check("both_reset_cycles", rstCnt, 4);
    check("both_reset_first", rstFirst, 7);
    check("both_halted", int'(bus.o_running), 0);

    // Instruction step: one 4-microcycle instruction, then HALTED.
    pressWindow(0, -1, 10, 30, enCnt, enFirst, enLast, rstCnt, rstFirst);
    check("istep_clkEn_count", enCnt, 4);
    check("istep_first", enFirst, 7);
    check("istep_last", enLast, 10);
    check("istep_halted", int'(bus.o_running), 0);
    check("istep_pc", int'(bus.i_pc), 32'h0004);

    // Reset pressed two cycles after step lands during STEP_INSTR; step is not replayed.
    pressWindow(0, 2, 12, 40, enCnt, enFirst, enLast, rstCnt, rstFirst);
    check("rstmid_clkEn_count", enCnt, 2);
    check("rstmid_clkEn_last", enLast, 8);
    check("rstmid_reset_cycles", rstCnt, 4);
    check("rstmid_reset_first", rstFirst, 9);
    check("rstmid_halted", int'(bus.o_running), 0);
    check("rstmid_pc", int'(bus.i_pc), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
